// File: rtl/reservation_station_issue_if.sv
`default_nettype none
// ============================================================================
// Module   : reservation_station_issue_if
// Purpose  : Dispatch, completion-bus, flush and FU-issue signals of one RS.
// Revision : 1.0 - initial release
// ============================================================================
interface reservation_station_issue_if #(
    parameter int ROB_SIZE_LOG = 5,
    parameter int CMDW         = 10,
    parameter int CNTW         = 3
);
    // dispatch from decode
    logic                    writeEn_i;
    logic [ROB_SIZE_LOG-1:0] robTag_i;
    logic [ROB_SIZE_LOG-1:0] tag1_i;
    logic [ROB_SIZE_LOG-1:0] tag2_i;
    logic [ROB_SIZE_LOG-1:0] tag3_i;
    logic [64:0]             val1_i;
    logic [64:0]             val2_i;
    logic [64:0]             val3_i;
    logic [CMDW-1:0]         commands_i;
    logic                    stall_o;
    logic [CNTW-1:0]         count_o;
    // completion bus and squash
    logic                    comValid_i;
    logic [ROB_SIZE_LOG-1:0] comTag_i;
    logic [64:0]             comVal_i;
    logic                    flush_i;
    // functional-unit issue port
    logic                    issueValid_o;
    logic                    fuReady_i;
    logic [ROB_SIZE_LOG-1:0] issueRobTag_o;
    logic [63:0]             issueVal1_o;
    logic [63:0]             issueVal2_o;
    logic [63:0]             issueVal3_o;
    logic [CMDW-1:0]         issueCommands_o;

    modport master (
        output writeEn_i, robTag_i, tag1_i, tag2_i, tag3_i,
               val1_i, val2_i, val3_i, commands_i,
               comValid_i, comTag_i, comVal_i, flush_i, fuReady_i,
        input  stall_o, count_o, issueValid_o, issueRobTag_o,
               issueVal1_o, issueVal2_o, issueVal3_o, issueCommands_o
    );

    modport slave (
        input  writeEn_i, robTag_i, tag1_i, tag2_i, tag3_i,
               val1_i, val2_i, val3_i, commands_i,
               comValid_i, comTag_i, comVal_i, flush_i, fuReady_i,
        output stall_o, count_o, issueValid_o, issueRobTag_o,
               issueVal1_o, issueVal2_o, issueVal3_o, issueCommands_o
    );
endinterface
`default_nettype wire

// File: rtl/reservation_station_issue.sv
`default_nettype none
// ============================================================================
// Module   : reservation_station_issue
// Purpose  : Age-ordered reservation station with completion-bus wakeup and
//            a valid/ready issue register; oldest ready op issues first.
//            Optional macro RS_BYPASS_EN: forward the completion value so an
//            op woken this cycle can be selected in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module reservation_station_issue #(
    parameter int ROB_SIZE     = 16,
    parameter int ROB_SIZE_LOG = $clog2(ROB_SIZE + 1),
    parameter int DEPTH        = 4,
    parameter int CMDW         = 10
) (
    input  wire logic                  clk_i,
    input  wire logic                  reset_i,
    reservation_station_issue_if.slave rs
);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_NSRC  = 3;

    typedef logic [ROB_SIZE_LOG-1:0] tag_t;
    typedef logic [63:0]             val_t;

    // ---------------- storage: slot 0 is the oldest entry ----------------
    tag_t               r_rob_tag [DEPTH];
    tag_t               r_src_tag [DEPTH][c_NSRC];
    val_t               r_src_val [DEPTH][c_NSRC];
    logic [CMDW-1:0]    r_cmd     [DEPTH];
    logic [c_CNT_W-1:0] r_count;

    logic               r_iss_valid;
    tag_t               r_iss_rob_tag;
    val_t               r_iss_val [c_NSRC];
    logic [CMDW-1:0]    r_iss_cmd;

    // ---------------- combinational signals ----------------
    logic               w_com_live;
    tag_t               w_in_tag    [c_NSRC];
    val_t               w_in_val    [c_NSRC];
    tag_t               w_in_wk_tag [c_NSRC];
    val_t               w_in_wk_val [c_NSRC];
    tag_t               w_wk_tag    [DEPTH][c_NSRC];
    val_t               w_wk_val    [DEPTH][c_NSRC];
    logic [DEPTH-1:0]   w_ready;
    logic               w_sel_found;
    logic [c_IDX_W-1:0] w_sel_idx;
    tag_t               w_sel_rob_tag;
    val_t               w_sel_val [c_NSRC];
    logic [CMDW-1:0]    w_sel_cmd;
    logic               w_stall;
    logic               w_accept;
    logic               w_iss_open;
    logic               w_take;
    logic [c_CNT_W-1:0] w_wr_idx;
    logic [c_CNT_W-1:0] w_nx_count;
    tag_t               w_nx_rob_tag [DEPTH];
    tag_t               w_nx_tag     [DEPTH][c_NSRC];
    val_t               w_nx_val     [DEPTH][c_NSRC];
    logic [CMDW-1:0]    w_nx_cmd     [DEPTH];
    logic               w_unused_msbs;

    // Tag 0 means "value present", so it must never be treated as a match.
    assign w_com_live = rs.comValid_i && (rs.comTag_i != '0);

    always_comb begin
        w_in_tag[0] = rs.tag1_i;
        w_in_tag[1] = rs.tag2_i;
        w_in_tag[2] = rs.tag3_i;
        w_in_val[0] = rs.val1_i[63:0];
        w_in_val[1] = rs.val2_i[63:0];
        w_in_val[2] = rs.val3_i[63:0];
        for (int k = 0; k < c_NSRC; k++) begin
            if (w_com_live && (w_in_tag[k] == rs.comTag_i)) begin
                w_in_wk_tag[k] = '0;
                w_in_wk_val[k] = rs.comVal_i[63:0];
            end else begin
                w_in_wk_tag[k] = w_in_tag[k];
                w_in_wk_val[k] = w_in_val[k];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            for (int k = 0; k < c_NSRC; k++) begin
                if (w_com_live && (r_src_tag[i][k] == rs.comTag_i)) begin
                    w_wk_tag[i][k] = '0;
                    w_wk_val[i][k] = rs.comVal_i[63:0];
                end else begin
                    w_wk_tag[i][k] = r_src_tag[i][k];
                    w_wk_val[i][k] = r_src_val[i][k];
                end
            end
        end
    end

    // Entries are compacted, so slot i is occupied exactly when i < count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_ready[i] = (c_CNT_W'(i) < r_count);
            for (int k = 0; k < c_NSRC; k++) begin
`ifdef RS_BYPASS_EN
                w_ready[i] = w_ready[i] && (w_wk_tag[i][k] == '0);
`else
                w_ready[i] = w_ready[i] && (r_src_tag[i][k] == '0);
`endif
            end
        end
    end

    // Scan from the youngest slot down so the oldest ready entry wins.
    always_comb begin
        w_sel_found   = 1'b0;
        w_sel_idx     = '0;
        w_sel_rob_tag = '0;
        w_sel_cmd     = '0;
        for (int k = 0; k < c_NSRC; k++) begin
            w_sel_val[k] = '0;
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_sel_found   = 1'b1;
                w_sel_idx     = c_IDX_W'(i);
                w_sel_rob_tag = r_rob_tag[i];
                w_sel_cmd     = r_cmd[i];
                for (int k = 0; k < c_NSRC; k++) begin
                    w_sel_val[k] = w_wk_val[i][k];
                end
            end
        end
    end

    assign w_stall    = (r_count == c_CNT_W'(DEPTH));
    assign w_accept   = rs.writeEn_i && !w_stall;
    assign w_iss_open = !r_iss_valid || rs.fuReady_i;
    assign w_take     = w_iss_open && w_sel_found;
    assign w_wr_idx   = r_count - c_CNT_W'(w_take);
    assign w_nx_count = r_count + c_CNT_W'(w_accept) - c_CNT_W'(w_take);

    // Shift everything above the removed slot down by one, then append.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            int j;
            j = (i < DEPTH - 1) ? i + 1 : i;
            w_nx_rob_tag[i] = r_rob_tag[i];
            w_nx_cmd[i]     = r_cmd[i];
            for (int k = 0; k < c_NSRC; k++) begin
                w_nx_tag[i][k] = w_wk_tag[i][k];
                w_nx_val[i][k] = w_wk_val[i][k];
            end
            if (w_take && (i < DEPTH - 1) && (i >= int'(w_sel_idx))) begin
                w_nx_rob_tag[i] = r_rob_tag[j];
                w_nx_cmd[i]     = r_cmd[j];
                for (int k = 0; k < c_NSRC; k++) begin
                    w_nx_tag[i][k] = w_wk_tag[j][k];
                    w_nx_val[i][k] = w_wk_val[j][k];
                end
            end
            if (w_accept && (c_CNT_W'(i) == w_wr_idx)) begin
                w_nx_rob_tag[i] = rs.robTag_i;
                w_nx_cmd[i]     = rs.commands_i;
                for (int k = 0; k < c_NSRC; k++) begin
                    w_nx_tag[i][k] = w_in_wk_tag[k];
                    w_nx_val[i][k] = w_in_wk_val[k];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rob_tag[i] <= '0;
                r_cmd[i]     <= '0;
                for (int k = 0; k < c_NSRC; k++) begin
                    r_src_tag[i][k] <= '0;
                    r_src_val[i][k] <= '0;
                end
            end
        end else if (rs.flush_i) begin
            r_count <= '0;
        end else begin
            r_count <= w_nx_count;
            for (int i = 0; i < DEPTH; i++) begin
                r_rob_tag[i] <= w_nx_rob_tag[i];
                r_cmd[i]     <= w_nx_cmd[i];
                for (int k = 0; k < c_NSRC; k++) begin
                    r_src_tag[i][k] <= w_nx_tag[i][k];
                    r_src_val[i][k] <= w_nx_val[i][k];
                end
            end
        end
    end

    // Issue register: payload only changes when a new op is loaded.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_iss_valid   <= 1'b0;
            r_iss_rob_tag <= '0;
            r_iss_cmd     <= '0;
            for (int k = 0; k < c_NSRC; k++) begin
                r_iss_val[k] <= '0;
            end
        end else if (rs.flush_i) begin
            r_iss_valid <= 1'b0;
        end else if (w_iss_open) begin
            r_iss_valid <= w_sel_found;
            if (w_sel_found) begin
                r_iss_rob_tag <= w_sel_rob_tag;
                r_iss_cmd     <= w_sel_cmd;
                for (int k = 0; k < c_NSRC; k++) begin
                    r_iss_val[k] <= w_sel_val[k];
                end
            end
        end
    end

    assign rs.stall_o         = w_stall;
    assign rs.count_o         = r_count;
    assign rs.issueValid_o    = r_iss_valid;
    assign rs.issueRobTag_o   = r_iss_rob_tag;
    assign rs.issueVal1_o     = r_iss_val[0];
    assign rs.issueVal2_o     = r_iss_val[1];
    assign rs.issueVal3_o     = r_iss_val[2];
    assign rs.issueCommands_o = r_iss_cmd;

    // Bit 64 of every value input carries no information for this block.
    assign w_unused_msbs = ^{rs.val1_i[64], rs.val2_i[64], rs.val3_i[64], rs.comVal_i[64]};

endmodule
`default_nettype wire

// File: tb/tb_reservation_station_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_reservation_station_issue
// Purpose  : Randomised + directed bench for reservation_station_issue with a
//            queue-based reference model and an issue-port scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reservation_station_issue;
    localparam int RSL   = 5;
    localparam int DEPTH = 4;
    localparam int CMDW  = 10;
    localparam int CNTW  = 3;

    typedef struct packed {
        logic [RSL-1:0]       rob;
        logic [2:0][RSL-1:0]  tag;
        logic [2:0][63:0]     val;
        logic [CMDW-1:0]      cmd;
    } op_t;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    op_t  m_q[$];
    op_t  exp_q[$];
    op_t  m_iss;
    bit   m_iss_v = 1'b0;

    always #5 clk = ~clk;

    reservation_station_issue_if #(.ROB_SIZE_LOG(RSL), .CMDW(CMDW), .CNTW(CNTW)) rs_bus ();

    reservation_station_issue #(.ROB_SIZE(16), .ROB_SIZE_LOG(RSL), .DEPTH(DEPTH), .CMDW(CMDW)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .rs      (rs_bus)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    function automatic op_t wake(input op_t o);
        op_t r = o;
        for (int k = 0; k < 3; k++) begin
            if (rs_bus.comValid_i && rs_bus.comTag_i != '0 && o.tag[k] == rs_bus.comTag_i) begin
                r.tag[k] = '0;
                r.val[k] = rs_bus.comVal_i[63:0];
            end
        end
        return r;
    endfunction

    function automatic bit eligible(input op_t o);
`ifdef RS_BYPASS_EN
        op_t w = wake(o);
        return w.tag == '0;
`else
        return o.tag == '0;
`endif
    endfunction

    function automatic op_t in_op();
        op_t o;
        o.rob    = rs_bus.robTag_i;
        o.tag[0] = rs_bus.tag1_i;
        o.tag[1] = rs_bus.tag2_i;
        o.tag[2] = rs_bus.tag3_i;
        o.val[0] = rs_bus.val1_i[63:0];
        o.val[1] = rs_bus.val2_i[63:0];
        o.val[2] = rs_bus.val3_i[63:0];
        o.cmd    = rs_bus.commands_i;
        return o;
    endfunction

    // Advance the model across the coming clock edge using the current inputs.
    function automatic void model_step();
        bit accept;
        bit open;
        int pick;
        if (m_iss_v && rs_bus.fuReady_i) exp_q.push_back(m_iss);
        if (rs_bus.flush_i) begin
            m_q.delete();
            m_iss_v = 1'b0;
            return;
        end
        accept = rs_bus.writeEn_i && (m_q.size() < DEPTH);
        open   = !m_iss_v || rs_bus.fuReady_i;
        pick   = -1;
        for (int i = 0; i < m_q.size(); i++) begin
            if (pick < 0 && eligible(m_q[i])) pick = i;
        end
        for (int i = 0; i < m_q.size(); i++) m_q[i] = wake(m_q[i]);
        if (open) begin
            if (pick >= 0) begin
                m_iss   = m_q[pick];
                m_q.delete(pick);
                m_iss_v = 1'b1;
            end else begin
                m_iss_v = 1'b0;
            end
        end
        if (accept) m_q.push_back(wake(in_op()));
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        rs_bus.writeEn_i  = 1'b0;
        rs_bus.robTag_i   = '0;
        rs_bus.tag1_i     = '0;
        rs_bus.tag2_i     = '0;
        rs_bus.tag3_i     = '0;
        rs_bus.val1_i     = '0;
        rs_bus.val2_i     = '0;
        rs_bus.val3_i     = '0;
        rs_bus.commands_i = '0;
        rs_bus.comValid_i = 1'b0;
        rs_bus.comTag_i   = '0;
        rs_bus.comVal_i   = '0;
        rs_bus.flush_i    = 1'b0;
    endtask

    task automatic dispatch(input logic [RSL-1:0] rob, input logic [RSL-1:0] t1,
                            input logic [RSL-1:0] t2, input logic [RSL-1:0] t3,
                            input logic [63:0] v1, input logic [CMDW-1:0] cmd);
        rs_bus.writeEn_i  = 1'b1;
        rs_bus.robTag_i   = rob;
        rs_bus.tag1_i     = t1;
        rs_bus.tag2_i     = t2;
        rs_bus.tag3_i     = t3;
        rs_bus.val1_i     = {1'($urandom), v1};
        rs_bus.val2_i     = {1'($urandom), $urandom, $urandom};
        rs_bus.val3_i     = {1'($urandom), $urandom, $urandom};
        rs_bus.commands_i = cmd;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #2;
        chk("count", 64'(rs_bus.count_o), 64'(m_q.size()));
        chk("stall", 64'(rs_bus.stall_o), 64'(m_q.size() == DEPTH));
        chk("issue_valid", 64'(rs_bus.issueValid_o), 64'(m_iss_v));
    endtask

    task automatic do_reset_async();
        reset_i = 1'b0;
        m_q.delete();
        exp_q.delete();
        m_iss_v = 1'b0;
        #1;
        chk("rst_count", 64'(rs_bus.count_o), 64'd0);
        chk("rst_stall", 64'(rs_bus.stall_o), 64'd0);
        chk("rst_issue_valid", 64'(rs_bus.issueValid_o), 64'd0);
        chk("rst_issue_tag", 64'(rs_bus.issueRobTag_o), 64'd0);
        chk("rst_issue_val1", rs_bus.issueVal1_o, 64'd0);
        chk("rst_issue_cmd", 64'(rs_bus.issueCommands_o), 64'd0);
        @(posedge clk);
        #2;
        reset_i = 1'b1;
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        forever begin : mon
            op_t e;
            @(negedge clk);
            if (reset_i && rs_bus.issueValid_o && rs_bus.fuReady_i) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL issue_unexpected: got tag 0x%0h, expected no issue", rs_bus.issueRobTag_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("issue_tag", 64'(rs_bus.issueRobTag_o), 64'(e.rob));
                    chk("issue_val1", rs_bus.issueVal1_o, e.val[0]);
                    chk("issue_val2", rs_bus.issueVal2_o, e.val[1]);
                    chk("issue_val3", rs_bus.issueVal3_o, e.val[2]);
                    chk("issue_cmd", 64'(rs_bus.issueCommands_o), 64'(e.cmd));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        idle();
        rs_bus.fuReady_i = 1'b1;
        #1;
        do_reset_async();

        // Ready dispatch reaches the issue register on the following edge.
        dispatch(5'd5, '0, '0, '0, 64'd7, 10'h011);
        step();
        idle();
        step();
        chk("t2_valid", 64'(rs_bus.issueValid_o), 64'd1);
        chk("t2_tag", 64'(rs_bus.issueRobTag_o), 64'd5);
        chk("t2_val1", rs_bus.issueVal1_o, 64'd7);
        step();

        // Completion wakeup of tag 3 with bit 64 set on the bus.
        dispatch(5'd6, 5'd3, '0, '0, 64'hDEAD, 10'h022);
        step();
        idle();
        rs_bus.comValid_i = 1'b1;
        rs_bus.comTag_i   = 5'd3;
        rs_bus.comVal_i   = {1'b1, 64'hAB};
        step();
        idle();
`ifdef RS_BYPASS_EN
        chk("t3_valid_1cyc", 64'(rs_bus.issueValid_o), 64'd1);
        chk("t3_val1", rs_bus.issueVal1_o, 64'hAB);
        step();
`else
        chk("t3_valid_1cyc", 64'(rs_bus.issueValid_o), 64'd0);
        step();
        chk("t3_valid_2cyc", 64'(rs_bus.issueValid_o), 64'd1);
        chk("t3_val1", rs_bus.issueVal1_o, 64'hAB);
`endif
        step();

        // Fill with the FU stalled: one op parks in the issue register, four fill the RS.
        rs_bus.fuReady_i = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            dispatch(RSL'(n), '0, '0, '0, {$urandom, $urandom}, CMDW'(n));
            step();
            if (n == 5) chk("t4_stall_full", 64'(rs_bus.stall_o), 64'd1);
        end
        chk("t4_count_after_drop", 64'(rs_bus.count_o), 64'd4);
        idle();
        rs_bus.fuReady_i = 1'b1;
        step();
        chk("t4_oldest_next", 64'(rs_bus.issueRobTag_o), 64'd2);
        for (int n = 0; n < 6; n++) step();

        // Younger ready op overtakes an older blocked one.
        dispatch(5'd7, 5'd2, '0, '0, 64'h70, 10'h007);
        step();
        dispatch(5'd8, '0, '0, '0, 64'h80, 10'h008);
        step();
        idle();
        step();
        chk("t5_young_first", 64'(rs_bus.issueRobTag_o), 64'd8);
        rs_bus.comValid_i = 1'b1;
        rs_bus.comTag_i   = 5'd2;
        rs_bus.comVal_i   = {1'b0, 64'h1234};
        step();
        idle();
`ifdef RS_BYPASS_EN
        chk("t5_old_second", 64'(rs_bus.issueRobTag_o), 64'd7);
        step();
`else
        step();
        chk("t5_old_second", 64'(rs_bus.issueRobTag_o), 64'd7);
`endif
        step();

        // Flush wins over a same-cycle dispatch.
        rs_bus.fuReady_i = 1'b0;
        for (int n = 0; n < 4; n++) begin
            dispatch(RSL'(9 + n), '0, '0, '0, {$urandom, $urandom}, CMDW'(n));
            step();
        end
        dispatch(5'd13, '0, '0, '0, 64'h13, 10'h013);
        rs_bus.flush_i = 1'b1;
        step();
        chk("t6_count", 64'(rs_bus.count_o), 64'd0);
        chk("t6_valid", 64'(rs_bus.issueValid_o), 64'd0);
        idle();
        step();

        // Asynchronous reset with three entries and a held issue.
        for (int n = 0; n < 4; n++) begin
            dispatch(RSL'(14 + n), '0, '0, '0, {$urandom, $urandom}, CMDW'(n));
            step();
        end
        chk("t1_count_before", 64'(rs_bus.count_o), 64'd3);
        idle();
        do_reset_async();

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            idle();
            if (c == 1500) begin
                do_reset_async();
                continue;
            end
            if ($urandom_range(0, 1) == 1) begin
                dispatch(RSL'($urandom_range(1, 16)),
                         ($urandom_range(0, 2) == 0) ? RSL'($urandom_range(1, 5)) : RSL'(0),
                         ($urandom_range(0, 2) == 0) ? RSL'($urandom_range(1, 5)) : RSL'(0),
                         ($urandom_range(0, 3) == 0) ? RSL'($urandom_range(1, 5)) : RSL'(0),
                         {$urandom, $urandom}, CMDW'($urandom));
            end
            if ($urandom_range(0, 2) == 0) begin
                rs_bus.comValid_i = 1'b1;
                rs_bus.comTag_i   = RSL'($urandom_range(0, 5));
                rs_bus.comVal_i   = {1'($urandom), $urandom, $urandom};
            end
            rs_bus.flush_i   = ($urandom_range(0, 149) == 0);
            rs_bus.fuReady_i = ($urandom_range(0, 3) != 0);
            step();
        end

        idle();
        rs_bus.fuReady_i = 1'b1;
        for (int n = 0; n < 10; n++) step();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
